// File: rtl/s_countdown.sv
// Two-digit BCD seconds countdown timer (99..00).
// A prescaler divides clk into a seconds tick while running; each tick
// decrements the loaded BCD value. The value holds 00 and done is raised at expiry.
module s_countdown #(
    parameter int TICK_DIV = 24000,
    parameter int CW       = 25
) (
    input  logic       clk,
    input  logic       res,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] s_tens,
    output logic [3:0] s_ones,
    output logic       running,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] con_t_q, con_t_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    // Out-of-range BCD nibbles saturate at 9 so the display never sees A-F.
    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // Next-state logic: load > pause > start, except that load is ignored in RUN.
    always_comb begin
        state_d = state_q;
        con_t_d = con_t_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    tens_d = clamp9(load_val[7:4]);
                    ones_d = clamp9(load_val[3:0]);
                end else if (pause) begin
                    // pause outranks start; nothing to pause in IDLE
                end else if (start && ((tens_q != 4'd0) || (ones_q != 4'd0))) begin
                    state_d = S_RUN;
                    con_t_d = '0;
                end
            end
            S_RUN: begin
                // The RUN cycle in which pause is seen still counts; the
                // prescaler is frozen only once the state is PAUSE.
                if (con_t_q == TICK_LAST) begin
                    con_t_d = '0;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                    if ((tens_q == 4'd0) && (ones_q <= 4'd1))
                        state_d = S_DONE;
                    else if (pause)
                        state_d = S_PAUSE;
                end else begin
                    con_t_d = con_t_q + CW'(1);
                    if (pause)
                        state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (load) begin
                    tens_d  = clamp9(load_val[7:4]);
                    ones_d  = clamp9(load_val[3:0]);
                    con_t_d = '0;
                    state_d = S_IDLE;
                end else if (pause) begin
                    // keep holding
                end else if (start) begin
                    // resume mid-second from the held prescaler value
                    state_d = S_RUN;
                end
            end
            default: begin
                if (load) begin
                    tens_d  = clamp9(load_val[7:4]);
                    ones_d  = clamp9(load_val[3:0]);
                    con_t_d = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Status outputs are registered copies of the next state.
    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // State, prescaler, digits and status flops; reset aborts immediately.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= S_IDLE;
            con_t_q   <= '0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            con_t_q   <= con_t_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign s_tens  = tens_q;
    assign s_ones  = ones_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_s_countdown.sv
// Directed bench for s_countdown with TICK_DIV=4.
module tb_s_countdown;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] s_tens, s_ones;
    logic       running, done;

    int n_cmp = 0;
    int n_bad = 0;
    int run_cyc = 0;
    int run_base;

    s_countdown #(.TICK_DIV(4), .CW(8)) dut (
        .clk(clk), .res(res), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .s_tens(s_tens), .s_ones(s_ones), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // Count cycles spent in RUN, sampled mid-cycle.
    always @(negedge clk) if (running === 1'b1) run_cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] t, input logic [3:0] o,
                           input logic r, input logic d);
        chk({tag, "_tens"}, 32'(s_tens), 32'(t));
        chk({tag, "_ones"}, 32'(s_ones), 32'(o));
        chk({tag, "_run"},  32'(running), 32'(r));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    initial begin
        // power-on reset
        #2;
        chk_all("por", 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk) res = 1'b0;

        // 1: reset during a run
        load = 1'b1; load_val = 8'h03; cyc(); load = 1'b0;
        chk_all("t1_load", 4'd0, 4'd3, 1'b0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t1_run", 4'd0, 4'd3, 1'b1, 1'b0);
        cyc(2);
        #2 res = 1'b1;
        #1 chk_all("t1_async", 4'd0, 4'd0, 1'b0, 1'b0);
        #1 res = 1'b0;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t1_start00", 4'd0, 4'd0, 1'b0, 1'b0);

        // 2: 03 counts down to 00 at edges 4/8/12
        load = 1'b1; load_val = 8'h03; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t2_e0", 4'd0, 4'd3, 1'b1, 1'b0);
        cyc(3);
        chk_all("t2_e3", 4'd0, 4'd3, 1'b1, 1'b0);
        cyc();
        chk_all("t2_e4", 4'd0, 4'd2, 1'b1, 1'b0);
        cyc(4);
        chk_all("t2_e8", 4'd0, 4'd1, 1'b1, 1'b0);
        cyc(3);
        chk_all("t2_e11", 4'd0, 4'd1, 1'b1, 1'b0);
        cyc();
        chk_all("t2_e12", 4'd0, 4'd0, 1'b0, 1'b1);
        cyc(3);
        chk_all("t2_hold", 4'd0, 4'd0, 1'b0, 1'b1);

        // 6: in DONE start ignored, load returns to IDLE
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t6_start", 4'd0, 4'd0, 1'b0, 1'b1);
        load = 1'b1; load_val = 8'h01; cyc(); load = 1'b0;
        chk_all("t6_load", 4'd0, 4'd1, 1'b0, 1'b0);

        // 3: borrow 10 -> 09, then down to 00
        load = 1'b1; load_val = 8'h10; cyc(); load = 1'b0;
        chk_all("t3_load", 4'd1, 4'd0, 1'b0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(4);
        chk_all("t3_borrow", 4'd0, 4'd9, 1'b1, 1'b0);
        cyc(35);
        chk_all("t3_e39", 4'd0, 4'd1, 1'b1, 1'b0);
        cyc();
        chk_all("t3_e40", 4'd0, 4'd0, 1'b0, 1'b1);

        // 5: clamp, load+start in IDLE, load ignored in RUN
        load = 1'b1; load_val = 8'hA7; cyc(); load = 1'b0;
        chk_all("t5_clamp", 4'd9, 4'd7, 1'b0, 1'b0);
        load = 1'b1; start = 1'b1; load_val = 8'h55; cyc(); load = 1'b0; start = 1'b0;
        chk_all("t5_ldstart", 4'd5, 4'd5, 1'b0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        load = 1'b1; load_val = 8'h42; cyc(); load = 1'b0;
        chk_all("t5_runload", 4'd5, 4'd5, 1'b1, 1'b0);
        #2 res = 1'b1;
        #1 chk_all("t5_abort", 4'd0, 4'd0, 1'b0, 1'b0);
        #1 res = 1'b0;
        cyc();

        // 4: pause after 2 RUN cycles for 10 cycles, resume
        load = 1'b1; load_val = 8'h05; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        run_base = run_cyc;
        cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        chk_all("t4_paused", 4'd0, 4'd5, 1'b0, 1'b0);
        cyc(9);
        chk_all("t4_held", 4'd0, 4'd5, 1'b0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t4_resume", 4'd0, 4'd5, 1'b1, 1'b0);
        cyc();
        chk_all("t4_r1", 4'd0, 4'd5, 1'b1, 1'b0);
        cyc();
        chk_all("t4_r2", 4'd0, 4'd4, 1'b1, 1'b0);
        cyc(15);
        chk_all("t4_r17", 4'd0, 4'd1, 1'b1, 1'b0);
        cyc();
        chk_all("t4_done", 4'd0, 4'd0, 1'b0, 1'b1);
        cyc(2);
        chk("t4_runcycles", 32'(run_cyc - run_base), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
